// File: rtl/robot_uart_tx_pkg.sv
// Shared definitions for the robot UART transmitter:
// FSM state encoding, frame width and default line parameters.
package robot_uart_tx_pkg;

    localparam int UART_BITS    = 8;
    localparam int DEF_CLK_FREQ = 50_000_000;
    localparam int DEF_BAUD     = 9600;
    localparam int DEF_FIFO_AW  = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

endpackage

// File: rtl/robot_uart_tx_if.sv
// Byte push port of the robot UART transmitter.
// Ports: tx_data (byte), tx_valid (byte offered), tx_ready (FIFO has room).
interface robot_uart_tx_if;
    import robot_uart_tx_pkg::*;

    logic [UART_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/robot_uart_tx_fifo.sv
// Synchronous FIFO, 2**AW entries, combinational read of the head entry.
// Ports: clk, reset (sync, high), push_i/wdata_i, pop_i/rdata_o,
//        empty_o, full_o, count_o (entries held, 0..2**AW).
module robot_uart_tx_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         empty_o,
    output logic         full_o,
    output logic [AW:0]  count_o
);

    logic [W-1:0]  mem_q [2**AW];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    // Count never exceeds 2**AW, so its top bit alone means full.
    assign full_o  = cnt_q[AW];
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rp_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wp_d  = do_push ? wp_q + AW'(1) : wp_q;
        rp_d  = do_pop  ? rp_q + AW'(1) : rp_q;
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wp_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/robot_uart_tx.sv
// Buffered UART transmitter, 8N1 (8E1 when ROBOT_UART_PARITY_EN is defined).
// Ports: clk, reset (sync, high), bus (slave push port), tx (serial,
//        idle high), busy (frame or queued bytes), fifo_count (queued bytes).
module robot_uart_tx
    import robot_uart_tx_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int BAUD     = DEF_BAUD,
    parameter int FIFO_AW  = DEF_FIFO_AW
) (
    input  logic             clk,
    input  logic             reset,
    robot_uart_tx_if.slave   bus,
    output logic             tx,
    output logic             busy,
    output logic [FIFO_AW:0] fifo_count
);

    localparam int DIVISOR = CLK_FREQ / BAUD;
    localparam int CW      = $clog2(DIVISOR);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [UART_BITS-1:0] data_q, data_d;
    logic                 tx_q, tx_d;

    logic                 pop;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [UART_BITS-1:0] fifo_rdata;
    logic                 bit_end;
    logic                 last_bit;

    robot_uart_tx_fifo #(
        .W  (UART_BITS),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (bus.tx_valid),
        .wdata_i (bus.tx_data),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign bus.tx_ready = ~fifo_full;
    assign tx           = tx_q;
    assign busy         = (state_q != ST_IDLE) | ~fifo_empty;

    assign bit_end  = (cnt_q == CW'(DIVISOR - 1));
    assign last_bit = (idx_q == 3'(UART_BITS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = ST_START;
            ST_START: if (bit_end) state_d = ST_DATA;
            ST_DATA: begin
                if (bit_end && last_bit) begin
`ifdef ROBOT_UART_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef ROBOT_UART_PARITY_EN
            ST_PARITY: if (bit_end) state_d = ST_STOP;
`endif
            ST_STOP: begin
                if (bit_end) begin
                    state_d = fifo_empty ? ST_IDLE : ST_START;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // tx_d is the line level for the next bit; loading a byte at the end
    // of STOP drives the start bit at once, giving back-to-back frames.
    always_comb begin
        tx_d   = tx_q;
        cnt_d  = cnt_q + CW'(1);
        idx_d  = idx_q;
        data_d = data_q;
        pop    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (!fifo_empty) begin
                    pop    = 1'b1;
                    data_d = fifo_rdata;
                    tx_d   = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_d = '0;
                    idx_d = '0;
                    tx_d  = data_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (last_bit) begin
`ifdef ROBOT_UART_PARITY_EN
                        tx_d = ^data_q;
`else
                        tx_d = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = data_q[idx_q + 3'd1];
                    end
                end
            end
`ifdef ROBOT_UART_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    cnt_d = '0;
                    tx_d  = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    tx_d  = 1'b1;
                    if (!fifo_empty) begin
                        pop    = 1'b1;
                        data_d = fifo_rdata;
                        tx_d   = 1'b0;
                    end
                end
            end
            default: begin
                cnt_d = '0;
                tx_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            data_q <= '0;
            tx_q   <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            data_q <= data_d;
            tx_q   <= tx_d;
        end
    end

endmodule

// File: tb/tb_robot_uart_tx.sv
// Self-checking bench for robot_uart_tx (CLK_FREQ=16, BAUD=1).
// Frame-timeline reference model plus directed tables and sequences.
module tb_robot_uart_tx;

    localparam int DIV = 16;
`ifdef ROBOT_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FLEN = NB * DIV;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx;
    logic       busy;
    logic [4:0] fifo_count;

    robot_uart_tx_if bus();

    robot_uart_tx #(
        .CLK_FREQ (16),
        .BAUD     (1),
        .FIFO_AW  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: bytes waiting, and position in the frame on the line.
    logic [7:0] mq[$];
    logic       m_act  = 1'b0;
    int         m_t    = 0;
    logic [7:0] m_byte = 8'h00;

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;
    } vec_t;
    vec_t vecs[6];

    function automatic logic frame_bit(logic [7:0] b, int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == NB - 1) return 1'b1;
        return ^b;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d",
                     name, cyc, act, exp);
        end
    endtask

    task automatic tick(logic r, logic v, logic [7:0] d);
        logic push;
        logic pop;
        logic etx;
        reset        = r;
        bus.tx_valid = v;
        bus.tx_data  = d;
        push = v && (mq.size() != DEPTH);
        @(posedge clk);
        cyc++;
        if (r) begin
            mq.delete();
            m_act = 1'b0;
            m_t   = 0;
        end else begin
            pop = (!m_act || m_t == FLEN - 1) && (mq.size() != 0);
            if (pop) begin
                m_byte = mq.pop_front();
                m_t    = 0;
                m_act  = 1'b1;
            end else if (m_act) begin
                if (m_t == FLEN - 1) m_act = 1'b0;
                else m_t++;
            end
            if (push) mq.push_back(d);
        end
        @(negedge clk);
        etx = m_act ? frame_bit(m_byte, m_t / DIV) : 1'b1;
        chk("tx", int'(tx), int'(etx));
        chk("tx_ready", int'(bus.tx_ready), int'(mq.size() != DEPTH));
        chk("busy", int'(busy), int'(m_act || mq.size() != 0));
        chk("fifo_count", int'(fifo_count), mq.size());
    endtask

    initial begin
        #5ms;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int cyc0;
        int low;
        logic got;
        int dens;
        logic r;
        logic v;

`ifdef ROBOT_UART_PARITY_EN
        vecs[0] = '{8'h55, 11'b1_0_01010101_0};
        vecs[1] = '{8'h07, 11'b1_1_00000111_0};
        vecs[2] = '{8'h03, 11'b1_0_00000011_0};
        vecs[3] = '{8'hA3, 11'b1_0_10100011_0};
        vecs[4] = '{8'h00, 11'b1_0_00000000_0};
        vecs[5] = '{8'hFF, 11'b1_0_11111111_0};
`else
        vecs[0] = '{8'h55, 11'b01_01010101_0};
        vecs[1] = '{8'h07, 11'b01_00000111_0};
        vecs[2] = '{8'h03, 11'b01_00000011_0};
        vecs[3] = '{8'hA3, 11'b01_10100011_0};
        vecs[4] = '{8'h00, 11'b01_00000000_0};
        vecs[5] = '{8'hFF, 11'b01_11111111_0};
`endif

        reset        = 1'b1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        @(negedge clk);

        repeat (3) tick(1'b1, 1'b0, 8'h00);
        chk("rst_tx", int'(tx), 1);
        chk("rst_ready", int'(bus.tx_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(fifo_count), 0);
        tick(1'b0, 1'b0, 8'h00);

        foreach (vecs[i]) begin
            tick(1'b0, 1'b1, vecs[i].data);
            for (int b = 0; b < NB; b++) begin
                for (int c = 0; c < DIV; c++) begin
                    tick(1'b0, 1'b0, 8'h00);
                    chk($sformatf("vec%0d_bit%0d", i, b),
                        int'(tx), int'(vecs[i].frame[b]));
                end
            end
            chk($sformatf("vec%0d_busy_in_stop", i), int'(busy), 1);
            tick(1'b0, 1'b0, 8'h00);
            chk($sformatf("vec%0d_busy_after", i), int'(busy), 0);
        end

        cyc0 = cyc;
        acc  = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.tx_ready) acc++;
            tick(1'b0, 1'b1, 8'(8'h10 + i));
        end
        chk("burst_accepted", acc, DEPTH + 1);
        chk("burst_count", int'(fifo_count), DEPTH);
        chk("burst_ready", int'(bus.tx_ready), 0);

        got = 1'b0;
        for (int i = 0; i < 2 * FLEN && !got; i++) begin
            got = bus.tx_ready;
            tick(1'b0, 1'b1, 8'hC3);
        end
        chk("refill_accepted", int'(got), 1);
        chk("refill_count", int'(fifo_count), DEPTH);
        chk("refill_ready", int'(bus.tx_ready), 0);

        for (int i = 0; i < 20 * FLEN && busy; i++) begin
            tick(1'b0, 1'b0, 8'h00);
        end
        chk("burst_drain_cycles", cyc - cyc0, 18 * FLEN + 2);

        tick(1'b0, 1'b1, 8'hA3);
        tick(1'b0, 1'b1, 8'h11);
        tick(1'b0, 1'b1, 8'h22);
        tick(1'b0, 1'b1, 8'h33);
        repeat (40) tick(1'b0, 1'b0, 8'h00);
        chk("pre_rst_count", int'(fifo_count), 3);
        chk("pre_rst_busy", int'(busy), 1);
        tick(1'b1, 1'b0, 8'h00);
        chk("mid_rst_tx", int'(tx), 1);
        chk("mid_rst_count", int'(fifo_count), 0);
        chk("mid_rst_busy", int'(busy), 0);
        low = 0;
        repeat (3 * FLEN) begin
            tick(1'b0, 1'b0, 8'h00);
            if (tx !== 1'b1) low++;
        end
        chk("no_frames_after_rst", low, 0);

        dens = 4;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) dens = $urandom_range(0, 8);
            r = ($urandom_range(0, 1499) == 0);
            v = ($urandom_range(0, 7) < dens);
            tick(r, v, 8'($urandom));
        end
        for (int i = 0; i < 20 * FLEN && busy; i++) begin
            tick(1'b0, 1'b0, 8'h00);
        end
        chk("rand_drained", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
